adxl345_spi_sequencer: RTL and testbench
========================================

// Module: adxl345_spi_sequencer
// PURPOSE
//  Master sequencer for the 16-bit SPI interface to the ADXL345. After reset it checks DEVID,
//  writes BW_RATE, DATA_FORMAT, POWER_CTL, then periodically reads DATAX0..DATAZ1 (0x32..0x37).
//  It publishes X/Y/Z as atomic 16-bit samples. Sits between the SPI_16BitInterface instance
//  and user logic; it is the only driver of that interface's start/data_in_16bit.
// PARAMETERS
//  SAMPLE_DIV      100000  clk cycles between sweep starts (1 kHz at 100 MHz); >= 1
//  BW_RATE_VAL     8'h0A   value written to reg 0x2C
//  DATA_FORMAT_VAL 8'h0B   value written to reg 0x31 (full-res, +/-16 g)
//  POWER_CTL_VAL   8'h08   value written to reg 0x2D (measure); written last
//  DEVID_EXP       8'hE5   expected contents of reg 0x00
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  enable        in   1   1 = run init/sampling; 0 = park in IDLE after current frame
//  spi_start     out  1   to SPI data interface start
//  spi_frame     out  16  to SPI data_in_16bit: [15]=R/W (1=read) [14]=MB=0 [13:8]=addr [7:0]=wdata
//  spi_busy      in   1   from SPI busy
//  spi_rdata     in   16  from SPI data_out_16bit; read byte = [7:0]
//  accel_x/y/z   out  16  {DATAn1,DATAn0}, two's complement as delivered by device
//  sample_valid  out  1   1-cycle pulse when accel_x/y/z update
//  init_done     out  1   high once POWER_CTL write has completed; sticky until reset
//  id_error      out  1   high when DEVID mismatched; sticky until reset
// BEHAVIOUR
//  Reset: spi_start=0, spi_frame=0, accel_*=0, sample_valid=0, init_done=0, id_error=0,
//   state=IDLE, indices/timer=0. Reset mid-frame: spi_start drops next edge; SPI reset separately.
//  Transaction handshake (every frame): REQ drives spi_frame and spi_start=1; start held until
//   spi_busy=1 is sampled, then start=0; WAIT until spi_busy=0; on that edge capture spi_rdata[7:0].
//   spi_frame stable from start rise until busy fall. One frame in flight at most.
//  States: IDLE -> (enable) ID_REQ -> ID_WAIT -> [rdata!=DEVID_EXP: ERROR] else CFG_REQ.
//   CFG_REQ/CFG_WAIT x3 (idx 0:0x2C,1:0x31,2:0x2D, R/W=0) -> init_done=1 -> RD_REQ.
//   RD_REQ/RD_WAIT x6 (addr 0x32+idx, R/W=1, wdata=0) bytes into shadow regs -> PUBLISH.
//   PUBLISH: accel_x/y/z <= shadow in one cycle, sample_valid=1 -> ARM.
//   ARM: wait until sample timer reaches SAMPLE_DIV-1, then RD_REQ (idx=0).
//   ERROR: terminal; no further frames; only reset exits.
//  Sample timer: cleared on entry to RD_REQ at idx 0, free-counts; if sweep lasts >= SAMPLE_DIV
//   cycles, ARM exits at once (no catch-up, no backlog).
//  enable=0: a frame in progress completes its handshake; sequencer then goes IDLE; shadow bytes
//   discarded, accel_* hold last published value. Re-enable: if init_done=1, resume at RD_REQ
//   idx 0 (no re-init); else restart at ID_REQ.
//  spi_busy already 1 in REQ (stale): start not asserted until busy=0 seen.
//  No partial publishes: accel_* never mix bytes from two sweeps.
// TESTING
//  Bench uses behavioural SPI slave: busy rises 2 clk after start, falls 200 clk later.
//  1 reset, enable=1, model DEVID=0xE5 -> frames 0x8000,0x2C0A,0x310B,0x2D08 in order; init_done=1.
//  2 DEVID=0x00 -> id_error=1, no frame after first; init_done stays 0 for 10k cycles.
//  3 regs 0x32..0x37 = 01,02,FE,FF,34,12 -> accel_x=0x0201, y=0xFFFE, z=0x1234, one sample_valid.
//  4 SAMPLE_DIV=2000 -> sweep starts exactly 2000 clk apart; SAMPLE_DIV=10 -> back-to-back, no gap.
//  5 enable=0 during 3rd read frame -> frame completes, IDLE, accel_* unchanged, no sample_valid;
//   re-enable -> next frame 0xB200 (no re-init).
//  6 reset asserted while spi_busy=1 -> next clk spi_start=0, all outputs at reset values.

Source files
------------

// File: rtl/adxl345_spi_sequencer.sv
// ADXL345 bring-up and sampling sequencer: DEVID check, three config writes, then periodic
// six-byte X/Y/Z sweeps over a 16-bit SPI frame interface, published atomically.
module adxl345_spi_sequencer #(
    parameter int unsigned SAMPLE_DIV      = 100000,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08,
    parameter logic [7:0]  DEVID_EXP       = 8'hE5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    output logic        spi_start_o,
    output logic [15:0] spi_frame_o,
    input  logic        spi_busy_i,
    input  logic [15:0] spi_rdata_i,
    output logic [15:0] accel_x_o,
    output logic [15:0] accel_y_o,
    output logic [15:0] accel_z_o,
    output logic        sample_valid_o,
    output logic        init_done_o,
    output logic        id_error_o
);

    localparam int unsigned    TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TW-1:0]  TIMER_TERM = TW'(SAMPLE_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ID_REQ, S_ID_WAIT, S_CFG_REQ, S_CFG_WAIT,
        S_RD_REQ, S_RD_WAIT, S_PUBLISH, S_ARM, S_ERROR
    } state_t;

    state_t          state_q;
    logic            start_q;
    logic [15:0]     frame_q;
    logic [2:0]      idx_q;
    logic [5:0][7:0] shadow_q;
    logic [15:0]     accel_x_q, accel_y_q, accel_z_q;
    logic            valid_q, init_done_q, id_error_q;
    logic [TW-1:0]   timer_q;
    logic            rdata_hi_unused;

    assign rdata_hi_unused = ^spi_rdata_i[15:8];

    function automatic logic [15:0] cfg_frame(input logic [2:0] i);
        case (i)
            3'd0:    cfg_frame = {2'b00, 6'h2C, BW_RATE_VAL};
            3'd1:    cfg_frame = {2'b00, 6'h31, DATA_FORMAT_VAL};
            default: cfg_frame = {2'b00, 6'h2D, POWER_CTL_VAL};
        endcase
    endfunction

    function automatic logic [15:0] rd_frame(input logic [2:0] i);
        rd_frame = {2'b10, 6'h32 + {3'b000, i}, 8'h00};
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            frame_q     <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            accel_x_q   <= '0;
            accel_y_q   <= '0;
            accel_z_q   <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            id_error_q  <= 1'b0;
            timer_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (timer_q != TIMER_TERM) timer_q <= timer_q + 1'b1;
            case (state_q)
                S_IDLE: if (enable_i) begin
                    if (init_done_q) begin
                        state_q <= S_RD_REQ;
                        idx_q   <= '0;
                        frame_q <= rd_frame(3'd0);
                        timer_q <= '0;
                    end else begin
                        state_q <= S_ID_REQ;
                        frame_q <= 16'h8000;
                    end
                end
                // Start is only raised once busy is seen low, so a stale busy never
                // counts as acceptance; once raised, the handshake always completes.
                S_ID_REQ, S_CFG_REQ, S_RD_REQ: begin
                    if (!start_q) begin
                        if (!enable_i)        state_q <= S_IDLE;
                        else if (!spi_busy_i) start_q <= 1'b1;
                    end else if (spi_busy_i) begin
                        start_q <= 1'b0;
                        state_q <= (state_q == S_ID_REQ)  ? S_ID_WAIT :
                                   (state_q == S_CFG_REQ) ? S_CFG_WAIT : S_RD_WAIT;
                    end
                end
                S_ID_WAIT: if (!spi_busy_i) begin
                    if (spi_rdata_i[7:0] != DEVID_EXP) begin
                        id_error_q <= 1'b1;
                        state_q    <= S_ERROR;
                    end else if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_CFG_REQ;
                        idx_q   <= '0;
                        frame_q <= cfg_frame(3'd0);
                    end
                end
                S_CFG_WAIT: if (!spi_busy_i) begin
                    if (idx_q == 3'd2) begin
                        init_done_q <= 1'b1;
                        if (enable_i) begin
                            state_q <= S_RD_REQ;
                            idx_q   <= '0;
                            frame_q <= rd_frame(3'd0);
                            timer_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_CFG_REQ;
                        idx_q   <= idx_q + 1'b1;
                        frame_q <= cfg_frame(idx_q + 1'b1);
                    end
                end
                S_RD_WAIT: if (!spi_busy_i) begin
                    shadow_q[idx_q] <= spi_rdata_i[7:0];
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (idx_q == 3'd5) begin
                        state_q <= S_PUBLISH;
                    end else begin
                        state_q <= S_RD_REQ;
                        idx_q   <= idx_q + 1'b1;
                        frame_q <= rd_frame(idx_q + 1'b1);
                    end
                end
                S_PUBLISH: begin
                    accel_x_q <= {shadow_q[1], shadow_q[0]};
                    accel_y_q <= {shadow_q[3], shadow_q[2]};
                    accel_z_q <= {shadow_q[5], shadow_q[4]};
                    valid_q   <= 1'b1;
                    state_q   <= S_ARM;
                end
                // Timer saturates, so an overlong sweep leaves ARM immediately with no backlog.
                S_ARM: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if (timer_q == TIMER_TERM) begin
                        state_q <= S_RD_REQ;
                        idx_q   <= '0;
                        frame_q <= rd_frame(3'd0);
                        timer_q <= '0;
                    end
                end
                S_ERROR: state_q <= S_ERROR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi_start_o    = start_q;
    assign spi_frame_o    = frame_q;
    assign accel_x_o      = accel_x_q;
    assign accel_y_o      = accel_y_q;
    assign accel_z_o      = accel_z_q;
    assign sample_valid_o = valid_q;
    assign init_done_o    = init_done_q;
    assign id_error_o     = id_error_q;

endmodule

// File: tb/tb_adxl345_spi_sequencer.sv
// Scoreboard bench: behavioural SPI slaves, expected frames/samples queued by stimulus,
// popped and compared by a negedge monitor.
module tb_adxl345_spi_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, en, start, busy, sv, idone, iderr;
    logic [15:0] frame, rdata, ax, ay, az;
    logic        rst2, en2, start2, busy2, sv2, idone2, iderr2;
    logic [15:0] frame2, rdata2, ax2, ay2, az2;

    adxl345_spi_sequencer #(.SAMPLE_DIV(2000)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .spi_start_o(start), .spi_frame_o(frame),
        .spi_busy_i(busy), .spi_rdata_i(rdata), .accel_x_o(ax), .accel_y_o(ay), .accel_z_o(az),
        .sample_valid_o(sv), .init_done_o(idone), .id_error_o(iderr));

    adxl345_spi_sequencer #(.SAMPLE_DIV(10)) dut2 (
        .clk_i(clk), .reset_i(rst2), .enable_i(en2), .spi_start_o(start2), .spi_frame_o(frame2),
        .spi_busy_i(busy2), .spi_rdata_i(rdata2), .accel_x_o(ax2), .accel_y_o(ay2), .accel_z_o(az2),
        .sample_valid_o(sv2), .init_done_o(idone2), .id_error_o(iderr2));

    int n_cmp = 0, n_bad = 0;
    logic [15:0] exp_f[$];
    logic [47:0] exp_s[$];
    logic [7:0]  regs [0:63];
    logic [7:0]  regs2[0:63];
    int          nframes = 0, nsamples = 0;
    int unsigned t_prev = 0, t_last = 0;
    logic        dut2_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) exp_f.push_back({8'hB2 + 8'(i), 8'h00});
    endtask

    task automatic set_rd(input logic [47:0] b);
        for (int i = 0; i < 6; i++) regs[6'h32 + 6'(i)] = b[47 - 8*i -: 8];
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, 64'(start), 64'h0);
        chk({tag, "_frame"}, 64'(frame), 64'h0);
        chk({tag, "_accel"}, 64'({ax, ay, az}), 64'h0);
        chk({tag, "_valid"}, 64'(sv), 64'h0);
        chk({tag, "_init_done"}, 64'(idone), 64'h0);
        chk({tag, "_id_error"}, 64'(iderr), 64'h0);
    endtask

    // SPI slave for dut: busy 2 clk after start, 200 clk busy, read byte from regs[addr]
    initial begin
        logic [15:0] sf;
        busy = 1'b0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (start && !busy) begin
                sf = frame;
                repeat (2) @(posedge clk);
                #1 busy = 1'b1;
                repeat (200) @(posedge clk);
                #1 rdata = sf[15] ? {8'h00, regs[sf[13:8]]} : 16'h0000;
                busy = 1'b0;
            end
        end
    end

    initial begin
        logic [15:0] sf;
        busy2 = 1'b0; rdata2 = '0;
        forever begin
            @(posedge clk); #1;
            if (start2 && !busy2) begin
                sf = frame2;
                repeat (2) @(posedge clk);
                #1 busy2 = 1'b1;
                repeat (200) @(posedge clk);
                #1 rdata2 = sf[15] ? {8'h00, regs2[sf[13:8]]} : 16'h0000;
                busy2 = 1'b0;
            end
        end
    end

    // Monitor: frame issue on start rise, frame stability at busy fall, samples on valid
    initial begin
        logic start_prev, busy_prev;
        logic [15:0] cur;
        start_prev = 1'b0; busy_prev = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (start && !start_prev) begin
                if (exp_f.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_frame: got %h expected none", frame);
                end else begin
                    chk("frame", 64'(frame), 64'(exp_f.pop_front()));
                end
                cur = frame;
                nframes++;
                if (frame == 16'hB200) begin t_prev = t_last; t_last = cyc; end
            end
            if (busy_prev && !busy && !rst) chk("frame_stable", 64'(frame), 64'(cur));
            if (sv) begin
                if (exp_s.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_sample: got %h expected none", {ax, ay, az});
                end else begin
                    chk("sample", 64'({ax, ay, az}), 64'(exp_s.pop_front()));
                end
                nsamples++;
            end
            start_prev = start; busy_prev = busy;
        end
    end

    // SAMPLE_DIV=10: sweeps run back-to-back, next start two cycles after sample_valid
    initial begin
        int unsigned c;
        for (int i = 0; i < 64; i++) regs2[i] = 8'h00;
        regs2[0] = 8'hE5; regs2[6'h32] = 8'h78; regs2[6'h33] = 8'h56;
        rst2 = 1'b1; en2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0; en2 = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 6000 && !sv2; k++) @(negedge clk);
            chk("div10_valid_seen", 64'(sv2), 64'h1);
            chk("div10_sample", 64'({ax2, ay2, az2}), 64'h5678_0000_0000);
            c = cyc;
            @(negedge clk);
            for (int k = 0; k < 20 && !start2; k++) @(negedge clk);
            chk("div10_gap", 64'(cyc - c), 64'd2);
            chk("div10_frame", 64'(frame2), 64'hB200);
        end
        dut2_done = 1'b1;
    end

    initial begin
        int nf0;
        logic ever_init;
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        rst = 1'b1; en = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");

        // Init sequence, then two sweeps 2000 clk apart
        regs[0] = 8'hE5;
        set_rd(48'h01_02_FE_FF_34_12);
        exp_f.push_back(16'h8000); exp_f.push_back(16'h2C0A);
        exp_f.push_back(16'h310B); exp_f.push_back(16'h2D08);
        push_sweep(6); push_sweep(6);
        exp_s.push_back(48'h0201_FFFE_1234);
        exp_s.push_back(48'h55AA_8000_7FFF);
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 5000 && nsamples < 1; k++) @(negedge clk);
        chk("sample1_seen", 64'(nsamples), 64'd1);
        set_rd(48'hAA_55_00_80_FF_7F);
        chk("init_done", 64'(idone), 64'h1);
        for (int k = 0; k < 5000 && nsamples < 2; k++) @(negedge clk);
        chk("sample2_seen", 64'(nsamples), 64'd2);
        chk("sweep_period", 64'(t_last - t_prev), 64'd2000);

        // Disable during third read frame: frame completes, nothing published
        set_rd(48'h11_22_33_44_55_66);
        nf0 = nframes;
        push_sweep(3);
        for (int k = 0; k < 5000 && nframes < nf0 + 3; k++) @(negedge clk);
        en = 1'b0;
        chk("third_frame_seen", 64'(nframes - nf0), 64'd3);
        repeat (3000) @(negedge clk);
        chk("hold_accel", 64'({ax, ay, az}), 64'h55AA_8000_7FFF);
        chk("no_sample_on_disable", 64'(nsamples), 64'd2);
        chk("busy_idle", 64'(busy), 64'h0);

        // Re-enable resumes at the first data read with no re-init
        push_sweep(6);
        exp_s.push_back(48'h2211_4433_6655);
        en = 1'b1;
        for (int k = 0; k < 5000 && nsamples < 3; k++) @(negedge clk);
        en = 1'b0;
        chk("sample3_seen", 64'(nsamples), 64'd3);
        chk("frames_drained", 64'(exp_f.size()), 64'd0);
        repeat (50) @(negedge clk);

        // DEVID mismatch: single frame, id_error, never init_done
        rst = 1'b1;
        repeat (3) @(negedge clk);
        regs[0] = 8'h00;
        exp_f.push_back(16'h8000);
        rst = 1'b0; en = 1'b1;
        ever_init = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            ever_init |= idone;
        end
        chk("id_error", 64'(iderr), 64'h1);
        chk("no_init_on_id_error", 64'(ever_init), 64'h0);
        chk("id_frame_issued", 64'(exp_f.size()), 64'd0);

        // Reset while the slave is busy
        en = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        regs[0] = 8'hE5;
        exp_f.push_back(16'h8000);
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 100 && !busy; k++) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'h1);
        @(posedge clk); #1 rst = 1'b1; en = 1'b0;
        @(posedge clk); #1 chk_reset_outputs("midframe_reset");
        for (int k = 0; k < 400 && busy; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 20000 && !dut2_done; k++) @(negedge clk);
        chk("div10_done", 64'(dut2_done), 64'h1);
        chk("frames_left", 64'(exp_f.size()), 64'd0);
        chk("samples_left", 64'(exp_s.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
